// File: rtl/text_buffer_writer.sv
// Character-cell text buffer: interprets an incoming byte stream (printables, newline,
// backspace, form feed) into a ROW_NUMBER x COL_NUMBER cell memory read by the renderer.
module text_buffer_writer #(
  parameter int                        ROW_NUMBER     = 15,
  parameter int                        COL_NUMBER     = 40,
  parameter int                        ROW_BIT_LEN    = 4,
  parameter int                        COL_BIT_LEN    = 6,
  parameter int                        CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID       = 8'h20,
  parameter int                        CELL_ADDR_LEN  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHAR_ID_LENGTH-1:0] char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic [ROW_BIT_LEN-1:0]    char_row,
  input  logic [COL_BIT_LEN-1:0]    char_col,
  output logic [CHAR_ID_LENGTH-1:0] character_id,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col
);

  localparam int CELLS = ROW_NUMBER * COL_NUMBER;
  localparam logic [CELL_ADDR_LEN-1:0] LAST_CELL     = CELL_ADDR_LEN'(CELLS - 1);
  localparam logic [CELL_ADDR_LEN-1:0] LAST_SRC_CELL = CELL_ADDR_LEN'((ROW_NUMBER - 1) * COL_NUMBER - 1);
  localparam logic [CELL_ADDR_LEN-1:0] LAST_ROW_BASE = CELL_ADDR_LEN'((ROW_NUMBER - 1) * COL_NUMBER);
  localparam logic [CELL_ADDR_LEN-1:0] ROW_STRIDE    = CELL_ADDR_LEN'(COL_NUMBER);
  localparam logic [ROW_BIT_LEN-1:0]   MAX_ROW       = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]   MAX_COL       = COL_BIT_LEN'(COL_NUMBER - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL, FILL} state_t;

  state_t                    state_reg;
  logic [CELL_ADDR_LEN-1:0]  idx_reg;
  logic [ROW_BIT_LEN-1:0]    row_reg;
  logic [COL_BIT_LEN-1:0]    col_reg;
  logic                      ready_reg;

  logic [CHAR_ID_LENGTH-1:0] mem [CELLS];

  logic                      accept, is_newline, is_backspace, is_clear, is_print, do_newline;
  logic [CELL_ADDR_LEN-1:0]  cur_addr, wr_addr;
  logic [CHAR_ID_LENGTH-1:0] wr_data;
  logic                      wr_en;

  function automatic logic [CELL_ADDR_LEN-1:0] cell_addr(input logic [ROW_BIT_LEN-1:0] r,
                                                         input logic [COL_BIT_LEN-1:0] c);
    return CELL_ADDR_LEN'(r) * ROW_STRIDE + CELL_ADDR_LEN'(c);
  endfunction

  assign char_ready = ready_reg;
  assign cursor_row = row_reg;
  assign cursor_col = col_reg;

  // Out-of-range lookups must not alias into neighbouring rows of the linear store.
  assign character_id = (char_row > MAX_ROW || char_col > MAX_COL) ? BLANK_ID
                                                                    : mem[cell_addr(char_row, char_col)];

  assign accept       = char_valid && ready_reg;
  assign is_newline   = (char_in == 8'h0A) || (char_in == 8'h0D);
  assign is_backspace = (char_in == 8'h08);
  assign is_clear     = (char_in == 8'h0C);
  assign is_print     = !(is_newline || is_backspace || is_clear);
  assign do_newline   = is_newline || (is_print && col_reg == MAX_COL);
  assign cur_addr     = cell_addr(row_reg, col_reg);

  // Single write port shared by clear, scroll, fill and the byte interpreter.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = idx_reg;
    wr_data = BLANK_ID;
    case (state_reg)
      CLEAR, FILL: wr_en = 1'b1;
      SCROLL: begin
        wr_en   = 1'b1;
        wr_data = mem[idx_reg + ROW_STRIDE];
      end
      IDLE: begin
        if (accept && is_print) begin
          wr_en   = 1'b1;
          wr_addr = cur_addr;
          wr_data = char_in;
        end else if (accept && is_backspace && cur_addr != '0) begin
          // Both in-row and row-wrapping backspace target the cell just before the cursor.
          wr_en   = 1'b1;
          wr_addr = cur_addr - 1'b1;
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (idx_reg == LAST_CELL) begin
            idx_reg   <= '0;
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            row_reg   <= '0;
            col_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_clear) begin
              idx_reg   <= '0;
              state_reg <= CLEAR;
              ready_reg <= 1'b0;
              row_reg   <= '0;
              col_reg   <= '0;
            end else if (is_backspace) begin
              if (col_reg != '0) begin
                col_reg <= col_reg - 1'b1;
              end else if (row_reg != '0) begin
                row_reg <= row_reg - 1'b1;
                col_reg <= MAX_COL;
              end
            end else if (do_newline) begin
              col_reg <= '0;
              if (row_reg < MAX_ROW) begin
                row_reg <= row_reg + 1'b1;
              end else begin
                idx_reg   <= '0;
                state_reg <= SCROLL;
                ready_reg <= 1'b0;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        SCROLL: begin
          if (idx_reg == LAST_SRC_CELL) begin
            idx_reg   <= LAST_ROW_BASE;
            state_reg <= FILL;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FILL: begin
          if (idx_reg == LAST_CELL) begin
            idx_reg   <= '0;
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

endmodule
